// File: rtl/uart_loopback_fifo.sv
// UART echo: received bytes are queued in a byte FIFO and drained to the transmitter.
// Optional CR->CRLF expansion is built only when UART_LB_CRLF_EN is defined.

module uart_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       rx_done,
    output logic [7:0] rx_data
);
    localparam int BAUD = CLK_FREQ / UART_BPS;
    localparam int CW   = $clog2(BAUD + 1);

    logic          rxd_s1;
    logic          rxd_s2;
    logic          rxd_s3;
    logic          busy;
    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift;

    // Synchronise the line and keep one extra stage for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_s3 <= 1'b1;
        end else begin
            rxd_s1 <= rxd;
            rxd_s2 <= rxd_s1;
            rxd_s3 <= rxd_s2;
        end
    end

    // Frame receiver; counter starts at 2 to absorb the synchroniser delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            rx_done <= 1'b0;
            rx_data <= '0;
        end else begin
            rx_done <= 1'b0;
            if (!busy) begin
                if (rxd_s3 && !rxd_s2) begin
                    busy    <= 1'b1;
                    clk_cnt <= CW'(2);
                    bit_cnt <= '0;
                end
            end else begin
                if (clk_cnt == CW'(BAUD - 1)) begin
                    clk_cnt <= '0;
                    bit_cnt <= bit_cnt + 4'd1;
                end else begin
                    clk_cnt <= clk_cnt + 1'b1;
                end
                if (clk_cnt == CW'(BAUD / 2)) begin
                    unique case (1'b1)
                        (bit_cnt == 4'd0): begin
                            if (rxd_s2) busy <= 1'b0;
                        end
                        (bit_cnt == 4'd9): begin
                            busy <= 1'b0;
                            if (rxd_s2) begin
                                rx_done <= 1'b1;
                                rx_data <= shift;
                            end
                        end
                        default: shift <= {rxd_s2, shift[7:1]};
                    endcase
                end
            end
        end
    end
endmodule

module uart_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_busy
);
    localparam int BAUD = CLK_FREQ / UART_BPS;
    localparam int CW   = $clog2(BAUD + 1);

    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shift;

    // Shift out start, eight data bits LSB first, then stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy <= 1'b0;
            txd     <= 1'b1;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '1;
        end else if (!tx_busy) begin
            txd <= 1'b1;
            if (tx_en) begin
                tx_busy <= 1'b1;
                txd     <= 1'b0;
                shift   <= {1'b1, tx_data};
                clk_cnt <= '0;
                bit_cnt <= '0;
            end
        end else if (clk_cnt == CW'(BAUD - 1)) begin
            clk_cnt <= '0;
            if (bit_cnt == 4'd9) begin
                tx_busy <= 1'b0;
                txd     <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                txd     <= shift[0];
                shift   <= {1'b1, shift[8:1]};
            end
        end else begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end
endmodule

module uart_loopback_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          uart_rxd,
    output logic                          uart_txd,
    input  logic                          ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          tx_active
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_HI,
        WAIT_LO
    } state_t;

    logic          uart_rx_done;
    logic [7:0]    uart_rx_data;
    logic          uart_tx_en;
    logic [7:0]    uart_tx_data;
    logic          uart_tx_busy;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop;
    logic          req_vld;
    logic [7:0]    req_data;
    logic          wr;
    logic          ovf_set;

    state_t        state;
    logic [1:0]    wait_cnt;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) u_rx (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .rxd     (uart_rxd),
        .rx_done (uart_rx_done),
        .rx_data (uart_rx_data)
    );

    uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) u_tx (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .tx_en   (uart_tx_en),
        .tx_data (uart_tx_data),
        .txd     (uart_txd),
        .tx_busy (uart_tx_busy)
    );

    assign full    = (fifo_level == (AW + 1)'(FIFO_DEPTH));
    assign pop     = (state == LOAD);
    assign wr      = req_vld && (!full || pop);
    assign ovf_set = req_vld && full && !pop;

`ifdef UART_LB_CRLF_EN
    logic       lf_pend;
    logic       stash_vld;
    logic [7:0] stash_data;

    // Write source: pending LF first, then a byte parked behind it, then RX
    always_comb begin
        req_vld  = lf_pend || stash_vld || uart_rx_done;
        req_data = uart_rx_data;
        if (lf_pend) begin
            req_data = 8'h0A;
        end else if (stash_vld) begin
            req_data = stash_data;
        end
    end

    // Track the LF owed after an accepted CR and park RX bytes that collide
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lf_pend    <= 1'b0;
            stash_vld  <= 1'b0;
            stash_data <= '0;
        end else begin
            if (lf_pend) begin
                lf_pend <= 1'b0;
            end else if (wr && req_data == 8'h0D) begin
                lf_pend <= 1'b1;
            end
            if (uart_rx_done && (lf_pend || stash_vld)) begin
                stash_vld  <= 1'b1;
                stash_data <= uart_rx_data;
            end else if (stash_vld && !lf_pend) begin
                stash_vld <= 1'b0;
            end
        end
    end
`else
    // Write source is the receiver directly
    always_comb begin
        req_vld  = uart_rx_done;
        req_data = uart_rx_data;
    end
`endif

    // Storage array; contents are don't-care until written
    always_ff @(posedge sys_clk) begin
        if (wr) mem[wr_ptr] <= req_data;
    end

    // Pointers and occupancy
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sticky overflow; a new drop beats a simultaneous clear
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // Drain FSM: pop one byte, kick the transmitter, retry if it never starts
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            tx_active    <= 1'b0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
            wait_cnt     <= '0;
        end else begin
            uart_tx_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fifo_level != '0 && !uart_tx_busy) begin
                        state     <= LOAD;
                        tx_active <= 1'b1;
                    end
                end
                LOAD: begin
                    uart_tx_data <= mem[rd_ptr];
                    uart_tx_en   <= 1'b1;
                    state        <= START;
                end
                START: begin
                    wait_cnt <= '0;
                    state    <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (uart_tx_busy) begin
                        state <= WAIT_LO;
                    end else if (wait_cnt == 2'd3) begin
                        uart_tx_en <= 1'b1;
                        state      <= START;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                WAIT_LO: begin
                    if (!uart_tx_busy) begin
                        state     <= IDLE;
                        tx_active <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    tx_active <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Bench for uart_loopback_fifo: serial driver, serial monitor and a queue model.
// Runs at 10 clocks per bit so full-frame scenarios stay short.

module tb_uart_loopback_fifo;
    localparam int CLK_FREQ = 1000000;
    localparam int UART_BPS = 100000;
    localparam int DEPTH    = 16;
    localparam int BIT      = CLK_FREQ / UART_BPS;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       uart_rxd  = 1'b1;
    logic       ovf_clr   = 1'b0;
    logic       uart_txd;
    logic [4:0] fifo_level;
    logic       overflow;
    logic       tx_active;

    int checks   = 0;
    int failures = 0;
    int rst_events = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[6];

    uart_loopback_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .UART_BPS   (UART_BPS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .uart_rxd   (uart_rxd),
        .uart_txd   (uart_txd),
        .ovf_clr    (ovf_clr),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .tx_active  (tx_active)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_rst_n) rst_events++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void model_rx(input logic [7:0] b);
        exp_q.push_back(b);
`ifdef UART_LB_CRLF_EN
        if (b == 8'h0D) exp_q.push_back(8'h0A);
`endif
    endfunction

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            uart_rxd = f[i];
            repeat (BIT - 1) @(negedge sys_clk);
        end
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < limit) begin
            @(negedge sys_clk);
            n++;
        end
        if (got_q.size() < exp_q.size())
            chk({name, "_timeout"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk(name, got_q.pop_front(), exp_q.pop_front());
        repeat (200) @(negedge sys_clk);
        chk({name, "_extra"}, got_q.size(), 0);
        got_q.delete();
        exp_q.delete();
    endtask

    // Serial monitor on uart_txd; frames cut by reset are discarded
    initial begin
        forever begin
            int         ev;
            logic [7:0] d;
            logic       ok;
            @(negedge uart_txd);
            if (sys_rst_n) begin
                ev = rst_events;
                ok = 1'b1;
                d  = '0;
                repeat (BIT / 2) @(negedge sys_clk);
                if (uart_txd !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge sys_clk);
                    d[i] = uart_txd;
                end
                repeat (BIT) @(negedge sys_clk);
                if (uart_txd !== 1'b1) ok = 1'b0;
                if (ok && ev == rst_events && sys_rst_n)
                    got_q.push_back(d);
            end
        end
    end

    initial begin
        int n;
        int lat;
        logic [7:0] base;

        vecs[0] = '{din: 8'h55, dout: 8'h55};
        vecs[1] = '{din: 8'h00, dout: 8'h00};
        vecs[2] = '{din: 8'hFF, dout: 8'hFF};
        vecs[3] = '{din: 8'h3C, dout: 8'h3C};
        vecs[4] = '{din: 8'h81, dout: 8'h81};
        vecs[5] = '{din: 8'h7E, dout: 8'h7E};

        repeat (3) @(negedge sys_clk);
        chk("rst_txd", uart_txd, 1);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_active", tx_active, 0);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        foreach (vecs[k]) begin
            send_byte(vecs[k].din);
            n = 0;
            while (got_q.size() == 0 && n < 400) begin
                @(negedge sys_clk);
                n++;
            end
            if (got_q.size() == 0) chk("vec_timeout", got_q.size(), 1);
            else chk("vec_echo", got_q.pop_front(), vecs[k].dout);
            n = 0;
            while (tx_active && n < 100) begin
                @(negedge sys_clk);
                n++;
            end
            chk("vec_level", fifo_level, 0);
            chk("vec_ovf", overflow, 0);
            got_q.delete();
        end

        fork
            send_byte(8'h5A);
        join_none
        n = 0;
        while (!dut.uart_rx_done && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        lat = 0;
        while (!dut.uart_tx_en && lat < 20) begin
            @(negedge sys_clk);
            lat++;
        end
        chk("latency", lat, 3);
        wait fork;
        model_rx(8'h5A);
        drain("lat_echo", 400);

        for (int i = 0; i < 20; i++) begin
            model_rx(8'(i));
            send_byte(8'(i));
        end
        drain("burst", 3000);
        chk("burst_ovf", overflow, 0);

        base = 8'($urandom_range(0, 255));
        for (int i = 0; i < 3 * DEPTH; i++) begin
            model_rx(base + 8'(i));
            send_byte(base + 8'(i));
        end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            model_rx(r);
            send_byte(r);
        end
        drain("wrap_rand", 4000);
        chk("wrap_ovf", overflow, 0);

        model_rx(8'h41);
        model_rx(8'h0D);
        send_byte(8'h41);
        send_byte(8'h0D);
        drain("crlf", 800);

        force dut.uart_tx_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            model_rx(8'h80 + 8'(i));
            send_byte(8'h80 + 8'(i));
        end
        repeat (5) @(negedge sys_clk);
        chk("fill_level", fifo_level, DEPTH);
        chk("fill_ovf", overflow, 0);
        send_byte(8'hEE);
        repeat (5) @(negedge sys_clk);
        chk("ovf_level", fifo_level, DEPTH);
        chk("ovf_set", overflow, 1);
        ovf_clr = 1'b1;
        @(negedge sys_clk);
        ovf_clr = 1'b0;
        @(negedge sys_clk);
        chk("ovf_clr", overflow, 0);
        release dut.uart_tx_busy;
        drain("ovf_drain", DEPTH * 150 + 500);
        chk("ovf_after", overflow, 0);
        chk("ovf_lvl0", fifo_level, 0);

        send_byte(8'hA5);
        n = 0;
        while (uart_txd !== 1'b0 && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        chk("a5_started", uart_txd, 0);
        repeat (35) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", uart_txd, 1);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_active", tx_active, 0);
        chk("mid_rst_ovf", overflow, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (300) @(negedge sys_clk);
        chk("rst_remnant", got_q.size(), 0);
        chk("rst_idle_txd", uart_txd, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_loopback_fifo.md
UART_LOOPBACK_FIFO -- requirements
Module: uart_loopback_fifo

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter UART_BPS, default 115200, line baud rate for both directions.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, number of byte entries; power of two, at least 4.
REQ-004 The block SHALL have port sys_clk, input, 1, single system clock; all logic rising-edge.
REQ-005 The block SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port uart_rxd, input, 1, serial receive line.
REQ-007 The block SHALL have port uart_txd, output, 1, serial transmit line, idle high.
REQ-008 The block SHALL have port ovf_clr, input, 1, one-cycle pulse that clears overflow.
REQ-009 The block SHALL have port fifo_level, output, log2(FIFO_DEPTH)+1, current entry count.
REQ-010 The block SHALL have port overflow, output, 1, sticky flag for a dropped byte.
REQ-011 The block SHALL have port tx_active, output, 1, high while the drain FSM is outside IDLE.

Function
REQ-012 Receive and transmit SHALL use the team's uart_rx and uart_tx sub-blocks, both passed CLK_FREQ and UART_BPS.
REQ-013 uart_rx_done high with the FIFO not full SHALL write uart_rx_data at the next rising edge; fifo_level rises by 1 on that edge.
REQ-014 uart_rx_done high with the FIFO full and no pop in the same cycle SHALL discard the byte and set overflow.
REQ-015 A write and a pop in the same cycle SHALL both take effect with fifo_level unchanged; this includes the full case, where the write is accepted.
REQ-016 Read and write pointers SHALL be log2(FIFO_DEPTH) bits and wrap from FIFO_DEPTH-1 to 0 without a gap.
REQ-017 The drain FSM SHALL have states IDLE, LOAD, START, WAIT_HI and WAIT_LO.
REQ-018 IDLE->LOAD SHALL occur when fifo_level is nonzero and uart_tx_busy is low.
REQ-019 LOAD SHALL pop the head entry into a holding register in one cycle, then go to START.
REQ-020 START SHALL drive uart_tx_en high for exactly one cycle with the holding register on uart_tx_data, then go to WAIT_HI.
REQ-021 WAIT_HI SHALL go to WAIT_LO when uart_tx_busy is 1.
REQ-022 WAIT_HI SHALL return to START if uart_tx_busy is still 0 after 4 cycles, resending the same byte.
REQ-023 WAIT_LO SHALL go to IDLE when uart_tx_busy returns to 0.
REQ-024 Bytes SHALL leave uart_txd in the exact order received, with none duplicated except by the REQ-022 resend.
REQ-025 With an empty FIFO and the FSM in IDLE, the minimum latency from uart_rx_done to uart_tx_en SHALL be 3 sys_clk cycles.
REQ-026 ovf_clr SHALL clear overflow; if ovf_clr and a new overflow occur in the same cycle, the set SHALL win.
REQ-027 An empty FIFO SHALL never be popped, and fifo_level SHALL never exceed FIFO_DEPTH.

Reset
REQ-028 Asserting sys_rst_n low SHALL, asynchronously and at any time including mid-frame: clear pointers and fifo_level to 0, clear overflow, put the FSM in IDLE, set tx_active to 0, set uart_tx_en to 0, and hold uart_txd at 1.
REQ-029 FIFO storage contents SHALL NOT require reset.
REQ-030 A frame interrupted by reset SHALL NOT be resumed after release.

Configuration
REQ-031 Macro UART_LB_CRLF_EN defined SHALL make a received 0x0D write two entries, 0x0D then 0x0A, in consecutive cycles.
REQ-032 Under UART_LB_CRLF_EN, if only one free entry exists, 0x0D SHALL be kept, 0x0A dropped, and overflow set.
REQ-033 Under UART_LB_CRLF_EN, the write port SHALL be held for the second write and an intervening uart_rx_done SHALL still be accepted.
REQ-034 With UART_LB_CRLF_EN undefined, 0x0D SHALL be treated as an ordinary byte and no insertion logic SHALL be synthesised.

Verification
REQ-035 Reset, then send 0x55 on uart_rxd -> 0x55 appears on uart_txd; fifo_level returns to 0; overflow stays 0.
REQ-036 Burst 0x00..0x13 back-to-back with FIFO_DEPTH=16 -> all 20 bytes echoed in order (TX drains during RX); overflow 0.
REQ-037 Hold uart_tx_busy high (forced) and send 17 bytes -> fifo_level=16, overflow=1; ovf_clr pulse -> overflow=0.
REQ-038 Assert sys_rst_n low mid-transmit of 0xA5 -> uart_txd=1 and fifo_level=0 immediately; after release, no remnant of 0xA5 is sent.
REQ-039 With UART_LB_CRLF_EN defined, send 0x41 0x0D -> output 0x41 0x0D 0x0A; with the macro undefined -> output 0x41 0x0D.
REQ-040 Pointer wrap: send 3 x FIFO_DEPTH bytes of an incrementing pattern at line rate -> output matches the input byte-for-byte.
